// File: rtl/ahb_instr_sequencer.sv
// Purpose : fetch/issue controller that walks instruction memory and hands each word to the AHB master.
// Latency : 4 cycles minimum per instruction (FETCH, ISSUE, WAIT, NEXT); longer while ready/done are late.
// Backpr. : cmd_valid holds with stable cmd_* until cmd_ready; WAIT stalls until cmd_done or TIMEOUT -> ERROR.
//
// Ports:
//   HCLK/HRESETn          clock, async active-low reset
//   start/stop            program control pulses
//   pc/instruction        instruction memory address out, 23-bit word in (combinational)
//   cmd_*                 command to master (valid/ready handshake), cmd_done/cmd_rdata completion
//   rd_valid/addr/data    1-cycle pulse carrying a captured read result
//   busy/halted/error     status flags
module ahb_instr_sequencer #(
    parameter int PC_WIDTH = 10,
    parameter int START_PC = 0,
    parameter int LAST_PC  = 19,
    parameter int TIMEOUT  = 15
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                start,
    input  logic                stop,
    output logic [PC_WIDTH-1:0] pc,
    input  logic [22:0]         instruction,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic                cmd_write,
    output logic [2:0]          cmd_burst,
    output logic                cmd_sel,
    output logic [9:0]          cmd_addr,
    output logic [7:0]          cmd_wdata,
    input  logic                cmd_done,
    input  logic [7:0]          cmd_rdata,
    output logic                rd_valid,
    output logic [9:0]          rd_addr,
    output logic [7:0]          rd_data,
    output logic                busy,
    output logic                halted,
    output logic                error
);

    typedef struct packed {
        logic       write;
        logic [2:0] burst;
        logic       sel;
        logic [9:0] addr;
        logic [7:0] data;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [PC_WIDTH-1:0] LP_START   = START_PC[PC_WIDTH-1:0];
    localparam logic [PC_WIDTH-1:0] LP_LAST    = LAST_PC[PC_WIDTH-1:0];
    localparam logic [PC_WIDTH-1:0] LP_ONE     = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]          LP_TIMEOUT = TIMEOUT[3:0];

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    instr_t              r_instr;
    logic [3:0]          r_wait_cnt;
    logic                r_stop_pend;
    logic                r_cmd_valid;
    logic                r_rd_valid;
    logic [9:0]          r_rd_addr;
    logic [7:0]          r_rd_data;
    logic                r_busy;
    logic                r_halted;
    logic                r_error;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_pc        <= LP_START;
            r_instr     <= '0;
            r_wait_cnt  <= '0;
            r_stop_pend <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;

            // r_busy tracks the current state, so stop is only latched while a program runs.
            // Placed before the case so that a HALT entry or restart in the same cycle clears it.
            if (stop && r_busy) begin
                r_stop_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        r_state     <= S_FETCH;
                        r_pc        <= LP_START;
                        r_stop_pend <= 1'b0;
                        r_busy      <= 1'b1;
                        r_halted    <= 1'b0;
                        r_error     <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_instr     <= instruction;
                    r_cmd_valid <= 1'b1;
                    r_state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_wait_cnt  <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // done is checked first so a completion on the timeout cycle still counts
                    if (cmd_done) begin
                        r_state <= S_NEXT;
                        if (!r_instr.write) begin
                            r_rd_valid <= 1'b1;
                            r_rd_addr  <= r_instr.addr;
                            r_rd_data  <= cmd_rdata;
                        end
                    end else if (r_wait_cnt == LP_TIMEOUT) begin
                        r_state <= S_ERROR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_NEXT: begin
                    if (r_stop_pend || (r_pc == LP_LAST)) begin
                        r_state     <= S_HALT;
                        r_busy      <= 1'b0;
                        r_halted    <= 1'b1;
                        r_stop_pend <= 1'b0;
                    end else begin
                        r_pc    <= r_pc + LP_ONE;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign cmd_valid = r_cmd_valid;
    assign cmd_write = r_instr.write;
    assign cmd_burst = r_instr.burst;
    assign cmd_sel   = r_instr.sel;
    assign cmd_addr  = r_instr.addr;
    assign cmd_wdata = r_instr.data;
    assign rd_valid  = r_rd_valid;
    assign rd_addr   = r_rd_addr;
    assign rd_data   = r_rd_data;
    assign busy      = r_busy;
    assign halted    = r_halted;
    assign error     = r_error;

endmodule

// File: tb/tb_ahb_instr_sequencer.sv
// Purpose : self-checking bench for ahb_instr_sequencer with a behavioural master and instruction memory.
// Latency : master ready/done delays come from the per-instruction vector table.
// Backpr. : master stalls cmd_ready and cmd_done per table entry, or withholds done entirely for timeout.
`timescale 1ns/1ps
module tb_ahb_instr_sequencer;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [9:0]  pc;
    logic [22:0] instruction;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        cmd_write;
    logic [2:0]  cmd_burst;
    logic        cmd_sel;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        cmd_done = 1'b0;
    logic [7:0]  cmd_rdata = 8'h00;
    logic        rd_valid;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        halted;
    logic        error;

    always #5 HCLK = ~HCLK;

    ahb_instr_sequencer dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .start       (start),
        .stop        (stop),
        .pc          (pc),
        .instruction (instruction),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_burst   (cmd_burst),
        .cmd_sel     (cmd_sel),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_done    (cmd_done),
        .cmd_rdata   (cmd_rdata),
        .rd_valid    (rd_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .halted      (halted),
        .error       (error)
    );

    // One program word plus the master behaviour for it and the decode the sequencer must present.
    typedef struct {
        logic [22:0] instr;
        int          rdy_dly;
        int          done_dly;
        logic [7:0]  rdata;
        logic        e_write;
        logic [2:0]  e_burst;
        logic        e_sel;
        logic [9:0]  e_addr;
        logic [7:0]  e_wdata;
        int          idx;
    } vec_t;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } rd_exp_t;

    vec_t        tbl [20];
    logic [22:0] imem [0:19];
    vec_t        cmd_q [$];
    rd_exp_t     rd_q [$];

    int checks = 0;
    int failures = 0;

    assign instruction = (pc < 10'd20) ? imem[pc[4:0]] : 23'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural master + read scoreboard ----------------
    int      m_rdy_cnt = -1;
    int      m_done_cnt = 0;
    bit      m_in_wait = 1'b0;
    bit      m_first = 1'b0;
    bit      m_no_done = 1'b0;
    int      m_hs = 0;
    vec_t    m_v;
    rd_exp_t m_r;
    rd_exp_t m_pop;

    always @(negedge HCLK) begin
        cmd_done  = 1'b0;
        cmd_ready = 1'b0;

        if (HRESETn && rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: rd_valid=1 addr=0x%0h data=0x%0h, required no read result", rd_addr, rd_data);
            end else begin
                m_pop = rd_q.pop_front();
                check("rd_addr", {22'd0, rd_addr}, {22'd0, m_pop.addr});
                check("rd_data", {24'd0, rd_data}, {24'd0, m_pop.data});
            end
        end

        if (!HRESETn || error) begin
            m_in_wait = 1'b0;
            m_rdy_cnt = -1;
        end else if (m_in_wait) begin
            if (m_first) begin
                check("cmd_valid_drop", {31'd0, cmd_valid}, 32'd0);
                m_first = 1'b0;
            end
            if (!m_no_done) begin
                if (m_done_cnt == 0) begin
                    cmd_done  = 1'b1;
                    cmd_rdata = m_v.rdata;
                    m_in_wait = 1'b0;
                    if (!m_v.e_write) begin
                        m_r.addr = m_v.e_addr;
                        m_r.data = m_v.rdata;
                        rd_q.push_back(m_r);
                    end
                end else begin
                    m_done_cnt--;
                end
            end
        end else if (cmd_valid) begin
            if (m_rdy_cnt < 0) begin
                if (cmd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cmd_unexpected: cmd_valid=1 at pc=%0d, required no command", pc);
                    m_v = tbl[0];
                end else begin
                    m_v = cmd_q.pop_front();
                end
                m_rdy_cnt = m_v.rdy_dly;
            end
            // fields and pc are compared on every presented cycle, so stalls also prove stability
            check("cmd_fields", {9'd0, cmd_write, cmd_burst, cmd_sel, cmd_addr, cmd_wdata},
                  {9'd0, m_v.e_write, m_v.e_burst, m_v.e_sel, m_v.e_addr, m_v.e_wdata});
            check("cmd_pc", {22'd0, pc}, m_v.idx);
            if (m_rdy_cnt == 0) begin
                cmd_ready  = 1'b1;
                m_in_wait  = 1'b1;
                m_first    = 1'b1;
                m_done_cnt = m_v.done_dly;
                m_hs++;
                m_rdy_cnt  = -1;
            end else begin
                m_rdy_cnt--;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push_program();
        for (int i = 0; i < 20; i++) begin
            cmd_q.push_back(tbl[i]);
        end
    endtask

    task automatic pulse_start(input logic with_stop);
        start = 1'b1;
        stop  = with_stop;
        @(negedge HCLK);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, {22'd0, pc}, 32'd0);
        check({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
        check({tag, "_cmd_fields"}, {9'd0, cmd_write, cmd_burst, cmd_sel, cmd_addr, cmd_wdata}, 32'd0);
        check({tag, "_rd"}, {13'd0, rd_valid, rd_addr, rd_data}, 32'd0);
        check({tag, "_flags"}, {29'd0, busy, halted, error}, 32'd0);
    endtask

    task automatic wait_halted(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 1500 && !ok; k++) begin
            @(negedge HCLK);
            ok = halted;
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_issue_at(input int want_pc, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge HCLK);
            ok = cmd_valid && (pc == want_pc[9:0]);
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_valid_low(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge HCLK);
            ok = !cmd_valid;
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    logic       g_w;
    logic [2:0] g_b;
    logic       g_s;
    logic [9:0] g_a;
    logic [7:0] g_d;
    int         hs0;
    bit         seen;

    initial begin
        // instr, rdy_dly, done_dly, rdata, write, burst, sel, addr, wdata, idx
        tbl[0] = '{23'b1_000_0_0000000001_00000010, 0, 0,  8'h00, 1'b1, 3'd0, 1'b0, 10'h001, 8'h02, 0};
        tbl[1] = '{23'b0_000_1_0000000100_00000000, 0, 0,  8'hA5, 1'b0, 3'd0, 1'b1, 10'h004, 8'h00, 1};
        tbl[2] = '{23'b1_011_1_1111111111_11111111, 5, 2,  8'h00, 1'b1, 3'd3, 1'b1, 10'h3FF, 8'hFF, 2};
        tbl[3] = '{23'b0_111_0_1000000000_01011010, 1, 3,  8'h3C, 1'b0, 3'd7, 1'b0, 10'h200, 8'h5A, 3};
        tbl[4] = '{23'b0_000_0_0000000000_00000000, 0, 0,  8'hFF, 1'b0, 3'd0, 1'b0, 10'h000, 8'h00, 4};
        tbl[5] = '{23'b1_001_0_0101010101_10101010, 2, 14, 8'h00, 1'b1, 3'd1, 1'b0, 10'h155, 8'hAA, 5};
        for (int i = 6; i < 20; i++) begin
            g_w = i[0];
            g_b = 3'(i);
            g_s = i[1];
            g_a = 10'(i * 37);
            g_d = 8'(i * 11 + 3);
            tbl[i] = '{{g_w, g_b, g_s, g_a, g_d}, i % 3, i % 4, 8'(i * 29), g_w, g_b, g_s, g_a, g_d, i};
        end
        for (int i = 0; i < 20; i++) begin
            imem[i] = tbl[i].instr;
        end

        // reset state
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        check_reset_outputs("reset");
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // full program; stop issued together with start from IDLE must be dropped
        push_program();
        hs0 = m_hs;
        pulse_start(1'b1);
        check("t1_fetch_busy", {31'd0, busy}, 32'd1);
        check("t1_fetch_pc", {22'd0, pc}, 32'd0);
        repeat (3) @(negedge HCLK);
        check("t1_next_pc", {22'd0, pc}, 32'd0);
        @(negedge HCLK);
        check("t1_pc_advanced", {22'd0, pc}, 32'd1);
        wait_halted("t3_halt_reached");
        check("t3_halt_pc", {22'd0, pc}, 32'd19);
        check("t3_handshakes", m_hs - hs0, 32'd20);
        check("t3_flags", {29'd0, busy, halted, error}, 32'b010);
        check("t3_cmds_left", cmd_q.size(), 32'd0);
        check("t3_reads_left", rd_q.size(), 32'd0);
        repeat (3) @(negedge HCLK);
        check("t3_halt_hold", {21'd0, halted, pc}, {21'd0, 1'b1, 10'd19});

        // restart from HALT, then stop while command 3 is waiting for completion
        push_program();
        hs0 = m_hs;
        pulse_start(1'b0);
        check("t3_restart", {20'd0, busy, halted, pc}, {20'd0, 1'b1, 1'b0, 10'd0});
        wait_issue_at(3, "t6_reach_pc3");
        wait_valid_low("t6_enter_wait");
        stop = 1'b1;
        @(negedge HCLK);
        stop = 1'b0;
        wait_halted("t6_halt_reached");
        check("t6_halt_pc", {22'd0, pc}, 32'd3);
        check("t6_handshakes", m_hs - hs0, 32'd4);
        check("t6_cmds_left", cmd_q.size(), 32'd16);
        check("t6_reads_left", rd_q.size(), 32'd0);
        cmd_q.delete();

        // timeout: master accepts command 0 but never completes it
        m_no_done = 1'b1;
        push_program();
        pulse_start(1'b0);
        wait_issue_at(0, "t5_reach_issue");
        for (int k = 0; k < 15; k++) begin
            @(negedge HCLK);
            check("t5_no_early_error", {30'd0, error, busy}, 32'b01);
        end
        seen = 1'b0;
        for (int k = 0; k < 3 && !seen; k++) begin
            @(negedge HCLK);
            seen = error;
        end
        check("t5_error_raised", {31'd0, seen}, 32'd1);
        check("t5_error_state", {28'd0, cmd_valid, busy, halted, error}, 32'b0001);
        check("t5_error_pc", {22'd0, pc}, 32'd0);
        m_no_done = 1'b0;
        cmd_q.delete();

        // restart from ERROR, then reset in the middle of command 5's wait
        push_program();
        pulse_start(1'b0);
        check("t5_restart", {20'd0, busy, error, pc}, {20'd0, 1'b1, 1'b0, 10'd0});
        wait_issue_at(5, "t6_reach_pc5");
        wait_valid_low("t6_pc5_wait");
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            check("post_reset_idle", {20'd0, cmd_valid, busy, pc}, 32'd0);
        end
        check("final_reads_left", rd_q.size(), 32'd0);
        cmd_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
